posit_encode_round: RTL

//  Output stage of the posit multiply datapath. Takes the unpacked product (sign, scale,

---
 rtl/posit_pkg.sv | 28 ++
 rtl/posit_regime_pack.sv | 61 ++++++
 rtl/posit_encode_round.sv | 107 ++++++++++
 3 files changed

// File: rtl/posit_pkg.sv
// Shared posit<N,ES> definitions for the multiply datapath: default geometry,
// saturation bound, special encodings and the unpacked product record.
package posit_pkg;

  localparam int P_N       = 16;
  localparam int P_ES      = 1;
  localparam int P_FRAC_W  = 28;
  localparam int P_SCALE_W = 8;

  // Largest scale whose regime still fits in N-1 bits.
  localparam int MAXSCALE = (P_N - 2) * (2 ** P_ES);

  localparam logic [P_N-1:0] NAR    = {1'b1, {(P_N-1){1'b0}}};
  localparam logic [P_N-1:0] ZERO   = '0;
  localparam logic [P_N-1:0] MAXPOS = {1'b0, {(P_N-1){1'b1}}};
  localparam logic [P_N-1:0] MINPOS = {{(P_N-1){1'b0}}, 1'b1};

  // Unpacked product as produced by the decoder/multiplier.
  typedef struct packed {
    logic                        sign;
    logic                        zero;
    logic                        nar;
    logic signed [P_SCALE_W-1:0] scale;
    logic [P_FRAC_W-1:0]         frac;
    logic                        sticky;
  } posit_prod_t;

endpackage

// File: rtl/posit_regime_pack.sv
// Combinational regime/exponent/fraction assembly. Produces the N-1 bit
// magnitude body (pre-rounding) plus guard and sticky bits. Out-of-range
// scales are saturated here so rounding downstream never moves them.
module posit_regime_pack
  import posit_pkg::*;
#(
  parameter int N       = P_N,
  parameter int ES      = P_ES,
  parameter int FRAC_W  = P_FRAC_W,
  parameter int SCALE_W = P_SCALE_W
) (
  input  logic [SCALE_W-1:0] scale,
  input  logic [FRAC_W-1:0]  frac,
  input  logic               sticky_in,
  output logic [N-2:0]       body,
  output logic               guard,
  output logic               sticky
);

  // Seed is {regime start pair, e, frac} followed by room to shift right.
  localparam int WW      = 2 + ES + FRAC_W + N - 1;
  localparam int MAXSC_L = (N - 2) * (2 ** ES);

  logic signed [SCALE_W-1:0] k;
  logic [ES-1:0]             e;
  logic [SCALE_W-1:0]        sh;
  logic signed [WW-1:0]      seed;
  logic signed [WW-1:0]      shifted;
  logic                      sat_hi;
  logic                      sat_lo;

  // k>=0: "10" seed arithmetic-shifted by k gives k+1 ones then 0.
  // k<0 : "01" seed shifted by -k-1 (= ~k) gives -k zeros then 1.
  always_comb begin
    k       = $signed(scale) >>> ES;
    e       = scale[ES-1:0];
    sat_hi  = int'($signed(scale)) >= MAXSC_L;
    sat_lo  = int'($signed(scale)) < -MAXSC_L;
    if (k >= 0) begin
      sh   = k;
      seed = {2'b10, e, frac, {(N-1){1'b0}}};
    end else begin
      sh   = ~k;
      seed = {2'b01, e, frac, {(N-1){1'b0}}};
    end
    shifted = seed >>> sh;
    body    = shifted[WW-1 -: N-1];
    guard   = shifted[WW-N];
    sticky  = (|shifted[WW-N-1:0]) | sticky_in;
    if (sat_hi) begin
      body   = {(N-1){1'b1}};
      guard  = 1'b0;
      sticky = 1'b0;
    end else if (sat_lo) begin
      body   = {{(N-2){1'b0}}, 1'b1};
      guard  = 1'b0;
      sticky = 1'b0;
    end
  end

endmodule

// File: rtl/posit_encode_round.sv
// Output stage of the posit multiplier: packs an unpacked product into
// posit<N,ES> over a 2-stage pipeline (assembly, then round/sign/specials).
// Handshake: a transfer happens on a cycle where valid && ready are both 1;
// valid and payload are held by the sender until that cycle, and ready may
// depend on the receiving side's state and its own downstream ready.
module posit_encode_round
  import posit_pkg::*;
#(
  parameter int N       = P_N,
  parameter int ES      = P_ES,
  parameter int FRAC_W  = P_FRAC_W,
  parameter int SCALE_W = P_SCALE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sign,
  input  logic               in_zero,
  input  logic               in_nar,
  input  logic [SCALE_W-1:0] in_scale,
  input  logic [FRAC_W-1:0]  in_frac,
  input  logic               in_sticky,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_posit
);

  localparam logic [N-1:0] NAR_L    = {1'b1, {(N-1){1'b0}}};
  localparam logic [N-1:0] MAXPOS_L = {1'b0, {(N-1){1'b1}}};

  logic [N-2:0] pk_body;
  logic         pk_guard;
  logic         pk_sticky;

  logic         s1_valid;
  logic [N-2:0] s1_body;
  logic         s1_guard;
  logic         s1_sticky;
  logic         s1_sign;
  logic         s1_zero;
  logic         s1_nar;

  logic         s2_adv;
  logic         round_up;
  logic [N-1:0] mag;
  logic [N-1:0] result;

  posit_regime_pack #(
    .N(N), .ES(ES), .FRAC_W(FRAC_W), .SCALE_W(SCALE_W)
  ) u_pack (
    .scale     (in_scale),
    .frac      (in_frac),
    .sticky_in (in_sticky),
    .body      (pk_body),
    .guard     (pk_guard),
    .sticky    (pk_sticky)
  );

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Stage 1 register: captures assembled body, round bits and flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_body   <= '0;
      s1_guard  <= 1'b0;
      s1_sticky <= 1'b0;
      s1_sign   <= 1'b0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_body   <= pk_body;
        s1_guard  <= pk_guard;
        s1_sticky <= pk_sticky;
        s1_sign   <= in_sign;
        s1_zero   <= in_zero;
        s1_nar    <= in_nar;
      end
    end
  end

  // Round-to-nearest-even, clamp a carry into the sign bit, then negate.
  always_comb begin
    round_up = s1_guard && (s1_body[0] || s1_sticky);
    mag      = {1'b0, s1_body} + {{(N-1){1'b0}}, round_up};
    if (mag[N-1]) mag = MAXPOS_L;
    result = s1_sign ? -mag : mag;
    if (s1_nar)       result = NAR_L;
    else if (s1_zero) result = '0;
  end

  // Stage 2 register: the output; holds while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_posit <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) out_posit <= result;
    end
  end

endmodule
